// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first: one full-adder cell plus a carry flip-flop
// produce a WIDTH-bit sum and carry-out in WIDTH cycles after an accepted start.
module serial_adder #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] a, b, partial;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic bit_sum, bit_carry, accept, last_bit;

  // The single full-adder cell, fed by the LSBs of the shift registers.
  assign bit_sum   = a[0] ^ b[0] ^ c;
  assign bit_carry = (a[0] & b[0]) | (c & (a[0] ^ b[0]));

  // A request is honoured only when no addition is running; DONE accepts
  // back-to-back so throughput is one operation per WIDTH+1 cycles.
  assign accept   = start && (state != SHIFT);
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves next_state
    // unassigned, which would infer a latch.
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = DONE;
      DONE:    next_state = accept ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a         <= '0;
      b         <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      partial   <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a       <= x;
      b       <= y;
      c       <= carry_in;
      cnt     <= '0;
      partial <= '0;
    end else if (state == SHIFT) begin
      a       <= a >> 1;
      b       <= b >> 1;
      c       <= bit_carry;
      cnt     <= cnt + CNT_W'(1);
      partial <= {bit_sum, partial[WIDTH-1:1]};
      // Result registers move only here, so they hold through the next SHIFT.
      if (last_bit) begin
        sum       <= {bit_sum, partial[WIDTH-1:1]};
        carry_out <= bit_carry;
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases with literal results plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         carry_in = 1'b0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
    .carry_in(carry_in), .busy(busy), .done(done), .sum(sum),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request yields x+y+carry_in WIDTH edges later.
  logic         m_busy = 1'b0, m_done = 1'b0, m_co = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic [W:0]   m_pend = '0;
  int           m_rem = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_co = 1'b0; m_rem = 0;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        {m_co, m_sum} = m_pend;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pend = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, carry_in};
        m_rem  = W;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("sum", sum, m_sum);
      check("carry_out", carry_out, m_co);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic ci);
    x = xa; y = ya; carry_in = ci; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for the done pulse; leaves time at the negedge where done=1.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n_done;
    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    tick();

    // 1: 3 + 5
    start_op(5'b00011, 5'b00101, 1'b0);
    @(negedge clk);
    check("t1_busy_after_accept", busy, 1);
    wait_done("t1");
    check("t1_sum", sum, 5'b01000);
    check("t1_co", carry_out, 0);
    check("t1_busy_in_done", busy, 0);
    tick();

    // 2: carry ripples out of the MSB
    start_op(5'b11111, 5'b00001, 1'b0);
    wait_done("t2a");
    check("t2a_sum", sum, 5'b00000);
    check("t2a_co", carry_out, 1);
    tick();
    start_op(5'b11111, 5'b11111, 1'b1);
    wait_done("t2b");
    check("t2b_sum", sum, 5'b11111);
    check("t2b_co", carry_out, 1);
    tick();

    // 3: start while busy is ignored
    start_op(5'b00001, 5'b00001, 1'b0);
    tick();
    start_op(5'b01010, 5'b00101, 1'b0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        check("t3_sum", sum, 5'b00010);
        check("t3_co", carry_out, 0);
      end
    end
    check("t3_done_count", n_done, 1);
    tick();

    // 4: start held high, back-to-back every WIDTH+1 cycles
    x = 5'b00110; y = 5'b00010; carry_in = 1'b0; start = 1'b1;
    n_done = 0;
    for (int i = 0; i < 3 * (W + 1); i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        check("t4_sum", sum, 5'b01000);
      end
    end
    start = 1'b0;
    check("t4_done_count", n_done, 3);
    repeat (2) tick();

    // 5: reset aborts an operation in flight
    start_op(5'b10100, 5'b01010, 1'b0);
    tick();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_sum", sum, 0);
    check("t5_co", carry_out, 0);
    #1 reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("t5_no_done", n_done, 0);
    tick();
    start_op(5'b10100, 5'b01010, 1'b0);
    wait_done("t5b");
    check("t5b_sum", sum, 5'b11110);
    check("t5b_co", carry_out, 0);
    tick();

    // 6: previous result held through SHIFT
    start_op(5'b00110, 5'b00010, 1'b0);
    wait_done("t6a");
    tick();
    start_op(5'b00000, 5'b00000, 1'b0);
    for (int i = 0; i < W - 1; i++) begin
      @(negedge clk);
      check("t6_hold_sum", sum, 5'b01000);
    end
    wait_done("t6b");
    check("t6_new_sum", sum, 5'b00000);
    check("t6_new_co", carry_out, 0);
    tick();

    // Randomized traffic, including starts while busy and rare resets.
    for (int i = 0; i < 2000; i++) begin
      x        = W'($urandom);
      y        = W'($urandom);
      carry_in = 1'($urandom);
      start    = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (2 * W) tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
